// File: rtl/jk_flip_flop.sv
// -----------------------------------------------------------------------------
// jk_flip_flop
//   Bank of WIDTH independent edge-triggered JK flip-flops with complementary
//   outputs. All lanes share one clock and one asynchronous active-low reset.
//
//   Per lane, on a rising clk edge with rst high:
//       J K
//       0 0  hold
//       0 1  clear  (q = 0)
//       1 0  set    (q = 1)
//       1 1  toggle (q = ~q)
//
// Parameters
//   WIDTH    number of independent lanes (>= 1)
//   RST_VAL  value forced onto q while reset is asserted
//
// Ports
//   clk    in   1      clock, state updates on rising edge
//   rst    in   1      asynchronous reset, active-low (0 = in reset)
//   J      in   WIDTH  per-lane set input, sampled on rising clk
//   K      in   WIDTH  per-lane clear input, sampled on rising clk
//   q      out  WIDTH  registered state
//   q_bar  out  WIDTH  bitwise complement of q
//
// Handshake: none. J/K are plain level inputs sampled at each rising clk edge;
// there is no valid/ready pairing and no combinational path from J/K to q.
// -----------------------------------------------------------------------------
module jk_flip_flop #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar
);

    logic [WIDTH-1:0] q_next;

    // Next-state per lane. Lanes never look at each other.
    always_comb begin
        q_next = q;
        for (int i = 0; i < WIDTH; i++) begin
            unique case ({J[i], K[i]})
                2'b00:   q_next[i] = q[i];
                2'b01:   q_next[i] = 1'b0;
                2'b10:   q_next[i] = 1'b1;
                2'b11:   q_next[i] = ~q[i];
                default: q_next[i] = q[i];
            endcase
        end
    end

    // Reset is asynchronous: it takes effect on its falling edge without a
    // clock and keeps winning at any clock edge while rst stays low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= RST_VAL;
        end else begin
            q <= q_next;
        end
    end

    // Derived from the register itself so it is the exact complement at all
    // times, including during reset.
    assign q_bar = ~q;

endmodule

// File: tb/tb_jk_flip_flop.sv
module tb_jk_flip_flop;

  localparam int W = 4;
  localparam logic [W-1:0] RV_B = 4'b1010;
  localparam logic [W-1:0] ALL1 = 4'b1111;

  // clock / reset block
  logic clk = 1'b0;
  logic rst;
  logic [W-1:0] J, K;
  logic [W-1:0] qa, qa_bar, qb, qb_bar;

  always #5 clk = ~clk;

  jk_flip_flop #(.WIDTH(W), .RST_VAL('0)) dut_a (
    .clk(clk), .rst(rst), .J(J), .K(K), .q(qa), .q_bar(qa_bar)
  );

  jk_flip_flop #(.WIDTH(W), .RST_VAL(RV_B)) dut_b (
    .clk(clk), .rst(rst), .J(J), .K(K), .q(qb), .q_bar(qb_bar)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] expb_q[$];
  logic [W-1:0] model_b;
  int total = 0;
  int bad = 0;

  typedef struct {
    logic [W-1:0] j;
    logic [W-1:0] k;
    logic [W-1:0] exp_q;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [W-1:0] jk_next(input logic [W-1:0] cur,
                                           input logic [W-1:0] j,
                                           input logic [W-1:0] k);
    logic [W-1:0] r;
    r = cur;
    for (int i = 0; i < W; i++) begin
      if (j[i] && k[i])  r[i] = ~cur[i];
      else if (j[i])     r[i] = 1'b1;
      else if (k[i])     r[i] = 1'b0;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [W-1:0] ea,
                           input logic [W-1:0] eb);
    check({name, "_qa"}, qa, ea);
    check({name, "_qa_bar"}, qa_bar, ~ea);
    check({name, "_qb"}, qb, eb);
    check({name, "_qb_bar"}, qb_bar, ~eb);
  endtask

  // driver: apply J/K at the falling edge, record expectation
  task automatic drive_vec(input logic [W-1:0] j, input logic [W-1:0] k,
                           input logic [W-1:0] ea);
    @(negedge clk);
    J = j;
    K = k;
    exp_q.push_back(ea);
    model_b = jk_next(model_b, j, k);
    expb_q.push_back(model_b);
  endtask

  // monitor: just after the rising edge, pop and compare
  task automatic collect(input string name);
    logic [W-1:0] ea, eb;
    @(posedge clk);
    #1;
    total++;
    if (exp_q.size() == 0 || expb_q.size() == 0) begin
      bad++;
      $display("FAIL %s_scoreboard: got empty queue want entry", name);
    end else begin
      total--;
      ea = exp_q.pop_front();
      eb = expb_q.pop_front();
      check_all(name, ea, eb);
    end
  endtask

  initial begin
    // table: {J, K, expected q of dut_a}
    vecs.push_back('{4'b0000, 4'b0000, 4'b0000});
    vecs.push_back('{4'b0000, 4'b0000, 4'b0000});
    vecs.push_back('{4'b0000, 4'b0000, 4'b0000});
    vecs.push_back('{4'b0000, 4'b0000, 4'b0000});
    vecs.push_back('{4'b0000, 4'b0000, 4'b0000});
    vecs.push_back('{4'b1111, 4'b0000, 4'b1111});
    vecs.push_back('{4'b0000, 4'b0000, 4'b1111});
    vecs.push_back('{4'b0000, 4'b1111, 4'b0000});
    vecs.push_back('{4'b1111, 4'b1111, 4'b1111});
    vecs.push_back('{4'b1111, 4'b1111, 4'b0000});
    vecs.push_back('{4'b1111, 4'b1111, 4'b1111});
    vecs.push_back('{4'b1111, 4'b1111, 4'b0000});
    vecs.push_back('{4'b0011, 4'b0101, 4'b0011});
    vecs.push_back('{4'b1010, 4'b0110, 4'b1001});
    vecs.push_back('{4'b1111, 4'b1001, 4'b0110});

    rst = 1'b1;
    J = '0;
    K = '0;
    model_b = RV_B;

    // async reset mid-cycle, no clock needed
    #2;
    rst = 1'b0;
    #1;
    check_all("reset_async", 4'b0000, RV_B);

    // reset holds across edges regardless of J/K
    J = ALL1;
    K = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_all("reset_hold", 4'b0000, RV_B);
    end

    @(negedge clk);
    rst = 1'b1;
    J = '0;
    K = '0;
    model_b = RV_B;

    // table-driven vectors
    for (int v = 0; v < vecs.size(); v++) begin
      drive_vec(vecs[v].j, vecs[v].k, vecs[v].exp_q);
      collect($sformatf("vec%0d", v));
    end

    // J/K only matter at the edge: glitch before the edge, change after it
    @(negedge clk);
    J = '0;
    K = ALL1;
    #2;
    J = ALL1;
    K = '0;
    model_b = jk_next(model_b, ALL1, 4'b0000);
    @(posedge clk);
    #1;
    check_all("edge_sample", ALL1, model_b);
    J = '0;
    K = ALL1;
    #2;
    check_all("between_edges", ALL1, model_b);

    @(negedge clk);
    J = '0;
    K = '0;

    // reset between edges from q=1, then release just after an edge
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_all("reset_midcycle", 4'b0000, RV_B);
    @(negedge clk);
    J = ALL1;
    K = ALL1;
    @(posedge clk);
    #1;
    check_all("reset_wins_edge", 4'b0000, RV_B);
    rst = 1'b1;
    #1;
    check_all("release_no_edge", 4'b0000, RV_B);
    @(posedge clk);
    #1;
    check_all("release_first_edge", ALL1, ~RV_B);
    @(posedge clk);
    #1;
    check_all("release_second_edge", 4'b0000, RV_B);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
